// File: rtl/bilinear_demosaicing_3x3_csr_pkg.sv
// Register indices of the bilinear_demosaicing_3x3 CSR slave.
package bilinear_demosaicing_3x3_csr_pkg;
  localparam int unsigned EN_CR_IDX      = 0;
  localparam int unsigned PATTERN_CR_IDX = 1;
endpackage

// File: rtl/demosaicing_cfg_sequencer_pkg.sv
// Types, register aliases and address/data helpers for demosaicing_cfg_sequencer.
package demosaicing_cfg_sequencer_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_WR,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_t;

  localparam int unsigned EN_CR_IDX      = bilinear_demosaicing_3x3_csr_pkg::EN_CR_IDX;
  localparam int unsigned PATTERN_CR_IDX = bilinear_demosaicing_3x3_csr_pkg::PATTERN_CR_IDX;
  localparam logic [1:0]  OKAY           = 2'b00;

  // idx 0 selects EN_CR, idx 1 selects PATTERN_CR
  function automatic logic [31:0] cr_addr(input logic [31:0] base, input logic idx);
    int unsigned reg_idx;
    reg_idx = idx ? PATTERN_CR_IDX : EN_CR_IDX;
    return base + (32'(reg_idx) << 2);
  endfunction

  function automatic logic [31:0] cr_value(input logic idx, input logic en,
                                           input logic [1:0] pattern);
    return idx ? {30'd0, pattern} : {31'd0, en};
  endfunction
endpackage

// File: rtl/axi4_lite_if.sv
// 32-bit AXI4-Lite bundle with master and slave views.
interface axi4_lite_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/demosaicing_cfg_sequencer.sv
// Writes enable and Bayer pattern to the demosaicing CSR slave at a frame
// boundary, reads both back, and reports mismatch, bus error or timeout.
module demosaicing_cfg_sequencer
  import demosaicing_cfg_sequencer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          SYNC_TO_FRAME  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cfg_req_i,
  input  logic       cfg_en_i,
  input  logic [1:0] cfg_pattern_i,
  input  logic       frame_sync_i,
  output logic       cfg_busy_o,
  output logic       cfg_done_o,
  output logic       cfg_err_o,
  axi4_lite_if.master csr_o
);
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              idx_q, idx_d;
  logic              en_q, en_d;
  logic [1:0]        pat_q, pat_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic [31:0]       awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic              aw_hs, w_hs, timeout, start_wr, start_ar, in_phase;

  assign aw_hs    = awvalid_q & csr_o.awready;
  assign w_hs     = wvalid_q & csr_o.wready;
  assign timeout  = (cnt_q == CNT_LAST);
  assign in_phase = (state_q == ST_WR) || (state_q == ST_B) ||
                    (state_q == ST_AR) || (state_q == ST_R);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    en_d      = en_q;
    pat_d     = pat_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    araddr_d  = araddr_q;
    start_wr  = 1'b0;
    start_ar  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_req_i) begin
          en_d  = cfg_en_i;
          pat_d = cfg_pattern_i;
          err_d = 1'b0;
          idx_d = 1'b0;
          if (SYNC_TO_FRAME) state_d = ST_WAIT_SYNC;
          else               start_wr = 1'b1;
        end
      end
      ST_WAIT_SYNC: begin
        if (frame_sync_i) start_wr = 1'b1;
      end
      ST_WR: begin
        // aw and w complete independently; remember each until both are in
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = ST_B;
          bready_d = 1'b1;
        end else if (timeout) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_B: begin
        if (csr_o.bvalid) begin
          bready_d = 1'b0;
          if (csr_o.bresp != OKAY) err_d = 1'b1;
          if (!idx_q) begin
            idx_d    = 1'b1;
            start_wr = 1'b1;
          end else begin
            idx_d    = 1'b0;
            start_ar = 1'b1;
          end
        end else if (timeout) begin
          bready_d = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_AR: begin
        if (csr_o.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end else if (timeout) begin
          arvalid_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_R: begin
        if (csr_o.rvalid) begin
          rready_d = 1'b0;
          if ((csr_o.rresp != OKAY) || (csr_o.rdata != cr_value(idx_q, en_q, pat_q)))
            err_d = 1'b1;
          if (!idx_q) begin
            idx_d    = 1'b1;
            start_ar = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else if (timeout) begin
          rready_d = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // address/data are loaded from the next idx so the valids rise registered
    if (start_wr) begin
      state_d   = ST_WR;
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      awaddr_d  = cr_addr(BASE_ADDR, idx_d);
      wdata_d   = cr_value(idx_d, en_d, pat_d);
    end
    if (start_ar) begin
      state_d   = ST_AR;
      arvalid_d = 1'b1;
      araddr_d  = cr_addr(BASE_ADDR, idx_d);
    end

    if ((state_d != state_q) || !in_phase) cnt_d = '0;
    else                                   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= 1'b0;
      en_q      <= 1'b0;
      pat_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      en_q      <= en_d;
      pat_q     <= pat_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      araddr_q  <= araddr_d;
    end
  end

  assign cfg_busy_o    = (state_q != ST_IDLE);
  assign cfg_done_o    = (state_q == ST_DONE);
  assign cfg_err_o     = err_q;

  assign csr_o.awvalid = awvalid_q;
  assign csr_o.awaddr  = awaddr_q;
  assign csr_o.awprot  = 3'b000;
  assign csr_o.wvalid  = wvalid_q;
  assign csr_o.wdata   = wdata_q;
  assign csr_o.wstrb   = 4'hF;
  assign csr_o.bready  = bready_q;
  assign csr_o.arvalid = arvalid_q;
  assign csr_o.araddr  = araddr_q;
  assign csr_o.arprot  = 3'b000;
  assign csr_o.rready  = rready_q;
endmodule

// File: tb/tb_demosaicing_cfg_sequencer.sv
// Bench for demosaicing_cfg_sequencer: CSR slave models, a transaction-level
// reference model with a per-cycle compare process, and directed scenarios.
module tb_demosaicing_cfg_sequencer;
  localparam logic [31:0] BASE0 = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- DUT 0: immediate write, short timeout ----------------
  axi4_lite_if bus0();
  logic       cfg_req0, cfg_en0, sync0;
  logic [1:0] cfg_pat0;
  logic       busy0, done0, err0;

  demosaicing_cfg_sequencer #(
    .BASE_ADDR(BASE0), .SYNC_TO_FRAME(1'b0), .TIMEOUT_CYCLES(16)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .cfg_req_i(cfg_req0), .cfg_en_i(cfg_en0),
    .cfg_pattern_i(cfg_pat0), .frame_sync_i(sync0), .cfg_busy_o(busy0),
    .cfg_done_o(done0), .cfg_err_o(err0), .csr_o(bus0)
  );

  // ---------------- DUT 1: frame-synchronised write ----------------
  axi4_lite_if bus1();
  logic       cfg_req1, cfg_en1, sync1;
  logic [1:0] cfg_pat1;
  logic       busy1, done1, err1;

  demosaicing_cfg_sequencer #(
    .BASE_ADDR(32'h0000_0000), .SYNC_TO_FRAME(1'b1), .TIMEOUT_CYCLES(1024)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .cfg_req_i(cfg_req1), .cfg_en_i(cfg_en1),
    .cfg_pattern_i(cfg_pat1), .frame_sync_i(sync1), .cfg_busy_o(busy1),
    .cfg_done_o(done1), .cfg_err_o(err1), .csr_o(bus1)
  );

  // ---------------- Slave 0 with fault knobs ----------------
  int          berr_idx   = -1;
  int          aw_stall   = 0;
  bit          no_arready = 1'b0;
  logic [31:0] regs0 [2];
  logic        aw_got, w_got;
  logic [31:0] aw_addr_l, w_data_l;
  int          aw_wait;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus0.awready <= 1'b0; bus0.wready <= 1'b0; bus0.bvalid <= 1'b0; bus0.bresp <= 2'b00;
      bus0.arready <= 1'b0; bus0.rvalid <= 1'b0; bus0.rdata <= '0; bus0.rresp <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; aw_addr_l <= '0; w_data_l <= '0; aw_wait <= 0;
      regs0[0] <= 32'd1; regs0[1] <= 32'd3;
    end else begin
      if (bus0.awvalid && bus0.awready) begin
        bus0.awready <= 1'b0; aw_got <= 1'b1; aw_addr_l <= bus0.awaddr; aw_wait <= 0;
      end else if (bus0.awvalid && !aw_got && !bus0.awready) begin
        if (aw_wait >= aw_stall) bus0.awready <= 1'b1;
        else aw_wait <= aw_wait + 1;
      end
      if (bus0.wvalid && bus0.wready) begin
        bus0.wready <= 1'b0; w_got <= 1'b1; w_data_l <= bus0.wdata;
      end else if (bus0.wvalid && !w_got && !bus0.wready) begin
        bus0.wready <= 1'b1;
      end
      if (bus0.bvalid && bus0.bready) begin
        bus0.bvalid <= 1'b0;
      end else if (aw_got && w_got && !bus0.bvalid) begin
        aw_got <= 1'b0; w_got <= 1'b0; bus0.bvalid <= 1'b1;
        if (berr_idx == int'(aw_addr_l[2])) bus0.bresp <= 2'b10;
        else begin
          bus0.bresp <= 2'b00;
          regs0[aw_addr_l[2]] <= w_data_l;
        end
      end
      if (bus0.rvalid && bus0.rready) bus0.rvalid <= 1'b0;
      if (bus0.arvalid && bus0.arready) begin
        bus0.arready <= 1'b0; bus0.rvalid <= 1'b1;
        bus0.rdata <= regs0[bus0.araddr[2]]; bus0.rresp <= 2'b00;
      end else if (bus0.arvalid && !bus0.arready && !no_arready && !bus0.rvalid) begin
        bus0.arready <= 1'b1;
      end
    end
  end

  // ---------------- Slave 1: always ready, OKAY ----------------
  logic [31:0] regs1 [2];
  assign bus1.awready = 1'b1;
  assign bus1.wready  = 1'b1;
  assign bus1.arready = 1'b1;
  assign bus1.bresp   = 2'b00;
  assign bus1.rresp   = 2'b00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus1.bvalid <= 1'b0; bus1.rvalid <= 1'b0; bus1.rdata <= '0;
      regs1[0] <= 32'd1; regs1[1] <= 32'd3;
    end else begin
      if (bus1.bvalid && bus1.bready) bus1.bvalid <= 1'b0;
      if (bus1.awvalid && bus1.wvalid) begin
        bus1.bvalid <= 1'b1;
        regs1[bus1.awaddr[2]] <= bus1.wdata;
      end
      if (bus1.rvalid && bus1.rready) bus1.rvalid <= 1'b0;
      if (bus1.arvalid) begin
        bus1.rvalid <= 1'b1;
        bus1.rdata  <= regs1[bus1.araddr[2]];
      end
    end
  end

  // ---------------- Reference model and compare process for DUT 0 ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       wq[$];
  logic [31:0] rq[$];
  logic [31:0] mregs [2];
  bit m_busy, m_done, done_next, m_err, m_err_hold, aw_seen, w_seen;
  bit chk_en = 1'b1;
  int aw_n, w_n;

  always @(negedge clk) begin
    bit          accept;
    logic [31:0] val [2];
    if (rst) begin
      m_busy = 0; m_done = 0; done_next = 0; m_err = 0; m_err_hold = 0;
      aw_seen = 0; w_seen = 0;
      mregs[0] = 32'd1; mregs[1] = 32'd3;
      wq.delete(); rq.delete();
    end else begin
      accept = !m_busy && cfg_req0;
      if (chk_en) begin
        check("busy", 32'(busy0), 32'(m_busy));
        check("done", 32'(done0), 32'(m_done));
        if (!m_busy) check("err_hold", 32'(err0), 32'(m_err_hold));
        if (m_done)  check("err_at_done", 32'(err0), 32'(m_err));
      end
      if (bus0.awvalid && bus0.awready) begin
        aw_n++;
        check("aw_expected", 32'(wq.size() != 0 && !aw_seen), 32'd1);
        if (wq.size() != 0) begin
          check("awaddr", bus0.awaddr, wq[0].addr);
          check("awprot", 32'(bus0.awprot), 32'd0);
        end
        aw_seen = 1;
      end
      if (bus0.wvalid && bus0.wready) begin
        w_n++;
        check("w_expected", 32'(wq.size() != 0 && !w_seen), 32'd1);
        if (wq.size() != 0) begin
          check("wdata", bus0.wdata, wq[0].data);
          check("wstrb", 32'(bus0.wstrb), 32'hF);
        end
        w_seen = 1;
      end
      if (aw_seen && w_seen) begin
        if (wq.size() != 0) void'(wq.pop_front());
        aw_seen = 0; w_seen = 0;
      end
      if (bus0.arvalid && bus0.arready) begin
        check("ar_expected", 32'(rq.size() != 0 && wq.size() == 0), 32'd1);
        if (rq.size() != 0) begin
          check("araddr", bus0.araddr, rq[0]);
          check("arprot", 32'(bus0.arprot), 32'd0);
          void'(rq.pop_front());
        end
      end
      if (bus0.rvalid && bus0.rready && rq.size() == 0 && wq.size() == 0) done_next = 1;

      if (m_done) begin
        m_done = 0; m_busy = 0; m_err_hold = m_err;
      end else if (done_next) begin
        m_done = 1; done_next = 0;
      end
      if (accept) begin
        m_busy = 1; aw_n = 0; w_n = 0;
        val[0] = {31'd0, cfg_en0};
        val[1] = {30'd0, cfg_pat0};
        m_err = no_arready;
        for (int i = 0; i < 2; i++) begin
          wq.push_back('{addr: BASE0 + 32'(i * 4), data: val[i]});
          rq.push_back(BASE0 + 32'(i * 4));
          if (berr_idx == i) m_err = 1;
          else mregs[i] = val[i];
        end
        for (int i = 0; i < 2; i++) if (mregs[i] != val[i]) m_err = 1;
      end
    end
  end

  // ---------------- Scenario helpers ----------------
  task automatic check_reset_outputs0(input string tag);
    check({tag, "_busy"},    32'(busy0), 0);
    check({tag, "_done"},    32'(done0), 0);
    check({tag, "_err"},     32'(err0), 0);
    check({tag, "_awvalid"}, 32'(bus0.awvalid), 0);
    check({tag, "_wvalid"},  32'(bus0.wvalid), 0);
    check({tag, "_bready"},  32'(bus0.bready), 0);
    check({tag, "_arvalid"}, 32'(bus0.arvalid), 0);
    check({tag, "_rready"},  32'(bus0.rready), 0);
    check({tag, "_awaddr"},  bus0.awaddr, 0);
    check({tag, "_wdata"},   bus0.wdata, 0);
    check({tag, "_araddr"},  bus0.araddr, 0);
  endtask

  task automatic request0(input logic en, input logic [1:0] pat);
    cfg_req0 = 1'b1; cfg_en0 = en; cfg_pat0 = pat;
    tick();
    cfg_req0 = 1'b0;
  endtask

  task automatic wait_done0(input string tag, output int n);
    n = 0;
    while (!done0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done0), 1);
  endtask

  int n;

  initial begin
    rst = 1'b1;
    cfg_req0 = 0; cfg_en0 = 0; cfg_pat0 = 0; sync0 = 0;
    cfg_req1 = 0; cfg_en1 = 0; cfg_pat1 = 0; sync1 = 0;
    repeat (3) tick();
    check_reset_outputs0("reset");
    check("reset_busy1", 32'(busy1), 0);
    check("reset_awvalid1", 32'(bus1.awvalid), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Plain sequence, en=0 pattern=2
    request0(1'b0, 2'd2);
    check("n1_busy", 32'(busy0), 1);
    check("n1_awvalid", 32'(bus0.awvalid), 1);
    check("n1_wvalid", 32'(bus0.wvalid), 1);
    check("n1_awaddr", bus0.awaddr, 32'h0000_1000);
    wait_done0("plain", n);
    check("plain_err", 32'(err0), 0);
    check("plain_reg_en", regs0[0], 32'd0);
    check("plain_reg_pat", regs0[1], 32'd2);
    repeat (3) tick();

    // SLVERR on the EN write: remaining transactions still run
    berr_idx = 0;
    request0(1'b1, 2'd1);
    wait_done0("berr", n);
    check("berr_err", 32'(err0), 1);
    check("berr_reg_pat", regs0[1], 32'd1);
    berr_idx = -1;
    repeat (3) tick();
    check("berr_err_sticky", 32'(err0), 1);

    // awready stalled while w completes first
    aw_stall = 5;
    request0(1'b1, 2'd0);
    wait_done0("stall", n);
    check("stall_aw_count", 32'(aw_n), 2);
    check("stall_w_count", 32'(w_n), 2);
    check("stall_err", 32'(err0), 0);
    check("stall_reg_pat", regs0[1], 32'd0);
    aw_stall = 0;
    repeat (3) tick();

    // arready never asserted: timeout after 16 cycles in AR
    no_arready = 1'b1;
    chk_en = 1'b0;
    request0(1'b0, 2'd3);
    n = 0;
    while (!bus0.arvalid && n < 300) begin
      tick();
      n++;
    end
    check("to_ar_entry", 32'(bus0.arvalid), 1);
    wait_done0("to", n);
    check("to_latency", 32'(n), 16);
    check("to_arvalid_dropped", 32'(bus0.arvalid), 0);
    check("to_err", 32'(err0), 1);
    tick();
    check("to_busy_dropped", 32'(busy0), 0);
    no_arready = 1'b0;
    m_busy = 0; m_done = 0; done_next = 0; m_err_hold = 1;
    aw_seen = 0; w_seen = 0;
    wq.delete(); rq.delete();
    chk_en = 1'b1;
    repeat (2) tick();

    // Reset while waiting for B, then a fresh sequence
    request0(1'b0, 2'd0);
    n = 0;
    while (!bus0.bready && n < 300) begin
      tick();
      n++;
    end
    check("rst_in_b_seen", 32'(bus0.bready), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs0("midrst");
    repeat (2) tick();
    check_reset_outputs0("midrst_hold");
    rst = 1'b0;
    tick();
    request0(1'b1, 2'd1);
    wait_done0("after_rst", n);
    check("after_rst_err", 32'(err0), 0);
    check("after_rst_reg_en", regs0[0], 32'd1);
    check("after_rst_reg_pat", regs0[1], 32'd1);
    repeat (3) tick();

    // Frame sync: pulse coincident with the request is ignored
    cfg_req1 = 1'b1; cfg_en1 = 1'b0; cfg_pat1 = 2'd1; sync1 = 1'b1;
    tick();
    cfg_req1 = 1'b0; sync1 = 1'b0;
    check("sync_busy", 32'(busy1), 1);
    for (int i = 1; i < 30; i++) begin
      check("sync_no_early_aw", 32'(bus1.awvalid), 0);
      tick();
    end
    check("sync_no_aw_at_pulse", 32'(bus1.awvalid), 0);
    sync1 = 1'b1;
    tick();
    sync1 = 1'b0;
    check("sync_aw_rise", 32'(bus1.awvalid), 1);
    check("sync_w_rise", 32'(bus1.wvalid), 1);
    n = 0;
    while (!done1 && n < 300) begin
      tick();
      n++;
    end
    check("sync_done_seen", 32'(done1), 1);
    check("sync_err", 32'(err1), 0);
    check("sync_reg_en", regs1[0], 32'd0);
    check("sync_reg_pat", regs1[1], 32'd1);
    tick();
    check("sync_busy_dropped", 32'(busy1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/demosaicing_cfg_sequencer.md
# demosaicing_cfg_sequencer

AXI4-Lite master that applies a new demosaicing configuration (enable, Bayer pattern) to the bilinear_demosaicing_3x3 CSR slave at a frame boundary. It then reads both registers back and flags any mismatch, bus error or timeout. It sits between the system control logic (pulse interface) and the demosaicing CSR port, so no software needs to touch the demosaicer mid-frame.

## Interface
- BASE_ADDR, 32'h0000_0000: byte base address of the demosaicing CSR slave.
- SYNC_TO_FRAME, 1: 1 = wait for frame_sync_i before writing; 0 = write immediately.
- TIMEOUT_CYCLES, 1024: max cycles any single AXI phase may wait for a handshake; minimum 2.
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- cfg_req_i  input  1  one-cycle request to apply new configuration.
- cfg_en_i  input  1  requested enable; sampled when the request is accepted.
- cfg_pattern_i  input  2  requested Bayer pattern; sampled when the request is accepted.
- frame_sync_i  input  1  one-cycle pulse at the frame boundary (vertical blank start).
- cfg_busy_o  output  1  high from request accept until the done pulse, inclusive.
- cfg_done_o  output  1  one-cycle pulse when the sequence ends (success or error).
- cfg_err_o  output  1  sticky error; valid with cfg_done_o; cleared on the next accepted request.
- csr_o  axi4_lite_if.master  —  AXI4-Lite master to the demosaicing CSR slave.

## Operation
- Register map: EN_CR at word 0 (bit 0), PATTERN_CR at word 1 (bits 1:0). Byte address = BASE_ADDR + (index << 2). Slave reset values: en = 1, pattern = 3.
- States:
  - IDLE: accepts cfg_req_i; latches en and pattern; clears the error bit; clears idx to 0.
  - WAIT_SYNC: waits for frame_sync_i. Entered only if SYNC_TO_FRAME = 1; otherwise the FSM goes directly to WR.
  - WR: drives awvalid and wvalid together. Each valid drops independently after its own handshake. Exits to B when both handshakes are done.
  - B: bready = 1. On bvalid: bresp ≠ 0 sets the error bit. If idx = 0, set idx = 1 and go to WR; if idx = 1, set idx = 0 and go to AR.
  - AR: drives arvalid until arready, then goes to R.
  - R: rready = 1. On rvalid: rresp ≠ 0 sets the error bit; rdata mismatching the latched value (zero-extended) sets the error bit. If idx = 0, set idx = 1 and go to AR; if idx = 1, go to DONE.
  - DONE: pulses cfg_done_o for one cycle and returns to IDLE.
- Write data and strobe: wdata is the value zero-extended to 32 bits; wstrb = 4'hF; awprot = arprot = 3'b000.
- Timeout: a per-state counter runs in WR, B, AR and R and resets on every state change. When it reaches TIMEOUT_CYCLES, the FSM drops all valids, sets the error bit and goes to DONE.
- An error does not abort the sequence, except on timeout; all remaining transactions still run.
- A cfg_req_i pulse while not in IDLE is ignored and not queued.

## Timing
- Reset values: all AXI valid signals 0, bready = rready = 0, addr/data 0, cfg_busy_o = 0, cfg_done_o = 0, cfg_err_o = 0, state IDLE.
- Reset mid-sequence returns to IDLE immediately (asynchronous); nothing is resumed.
- All AXI outputs are registered.
- Request handling: the request is accepted in cycle N with the FSM in IDLE. cfg_busy_o rises at N+1. With SYNC_TO_FRAME = 0, awvalid and wvalid also rise at N+1.
- frame_sync_i only counts from the first cycle in WAIT_SYNC. A sync pulse in the same cycle as the request is ignored and the FSM waits for the next one.
- After a frame_sync_i pulse in cycle M (in WAIT_SYNC), awvalid and wvalid rise at M+1.
- A valid stays asserted until its handshake cycle and deasserts the following cycle. A handshake is never lost when aw and w complete in different cycles.
- cfg_done_o is asserted in the cycle after the final R handshake. cfg_busy_o drops in the cycle after cfg_done_o.
- cfg_err_o holds its value until the next accepted request.

## Structure
- Package demosaicing_cfg_sequencer_pkg holds:
  - the state enum;
  - EN_CR_IDX = 0 and PATTERN_CR_IDX = 1, aliased from bilinear_demosaicing_3x3_csr_pkg;
  - OKAY = 2'b00.
- Optional sub-module axi4_lite_single_xfer: a one-shot write/read engine with its own timeout. The FSM loops over idx to drive it.

## Test plan
- SYNC_TO_FRAME = 0; request en = 0, pattern = 2 against the real CSR slave -> slave registers read 0 and 2; cfg_done_o pulses once; cfg_err_o = 0.
- SYNC_TO_FRAME = 1; request at cycle 10, frame_sync_i at cycle 10 and cycle 40 -> awvalid rises at cycle 41, not earlier.
- Slave model returns bresp = 2'b10 on the EN write -> all remaining transactions complete; cfg_err_o = 1 at done.
- Slave model stalls awready while wready completes first -> exactly one aw handshake and one w handshake occur; the readback pattern matches.
- Slave model never asserts arready, TIMEOUT_CYCLES = 16 -> arvalid drops; cfg_done_o pulses 16 cycles after AR entry; cfg_err_o = 1.
- rst_i asserted while in state B, then a new request en = 1, pattern = 1 -> all outputs are 0 during reset; the new sequence completes with cfg_err_o = 0.
